fp_add_issuer: RTL and testbench
================================

// Module: fp_add_issuer
// PURPOSE
//  Host-side initiator for the floating-point adder (datapath + controller pair).
//  Accepts packed IEEE-754 single operands over valid/ready and unpacks them into sign/exp/24-bit mantissa.
//  Drives the adder's start/done handshake, packs the result back to 32 bits and presents it over valid/ready.
//  Includes a watchdog so a hung adder cannot stall the host.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max WAIT-state cycles before abort; legal range 1..2**CNT_W-1
//  CNT_W           8    watchdog counter width
// PORTS
//  clk           in   1   system clock, rising edge
//  rst           in   1   asynchronous, active-LOW reset
//  in_valid      in   1   host operand pair valid
//  in_ready      out  1   issuer can accept an operand pair
//  in_a          in   32  operand A, IEEE-754 single
//  in_b          in   32  operand B, IEEE-754 single
//  in_op         in   1   0 = A+B, 1 = A-B
//  parin_s_A     out  1   A sign to adder
//  parin_exp_A   out  8   A exponent to adder
//  parin_mant_A  out  24  A mantissa to adder, hidden bit at [23]
//  parin_s_B     out  1   B sign to adder
//  parin_exp_B   out  8   B exponent to adder
//  parin_mant_B  out  24  B mantissa to adder, hidden bit at [23]
//  operator      out  1   registered copy of in_op
//  start         out  1   adder start
//  done          in   1   adder completion
//  s_outR        in   1   adder result sign
//  exp_outR      in   8   adder result exponent
//  mant_outR     in   24  adder result mantissa, hidden bit at [23]
//  out_valid     out  1   packed result valid
//  out_ready     in   1   host accepts result
//  out_result    out  32  packed IEEE-754 result
//  out_timeout   out  1   qualifies out_result: 1 = watchdog abort
// BEHAVIOUR
//  Reset (rst low, async): state IDLE; every output 0 except in_ready = 1; watchdog counter = 0.
//  FSM states:
//   IDLE:  in_ready=1. On in_valid&in_ready: register operands and op -> ISSUE.
//   ISSUE: start=1 for exactly this one cycle; done is ignored here. Clear counter -> WAIT.
//   WAIT:  start=0; counter increments each cycle.
//          On done=1, capture the result and set out_timeout=0 -> HOLD.
//          Else, when counter==TIMEOUT_CYCLES-1: out_result=32'h7FC00000, out_timeout=1 -> HOLD.
//          If done coincides with the terminal count, done wins.
//   HOLD:  out_valid=1; out_result and out_timeout stay stable. On out_ready -> IDLE.
//  Unpack (per operand):
//   s = w[31]; exp = w[30:23].
//   mant = {hidden, w[22:0]}, where hidden = (exp != 0). Denormals and zero get hidden = 0.
//  Pack: out_result = {s_outR, exp_outR, mant_outR[22:0]}.
//   Exception: if mant_outR == 0, out_result = {s_outR, 31'b0}.
//  Adder-side outputs (parin_*, operator) stay stable from ISSUE until the next accept. They do not return to 0 between ops.
//  Latency: accept edge -> ISSUE (1 cycle) -> WAIT (>=1 cycle) -> HOLD.
//   out_valid rises 1 cycle after the first done-high cycle in WAIT.
//  No combinational bypass:
//   in_ready returns 1 in the cycle after the out handshake.
//   Max throughput is one op per 4 + adder-latency cycles.
//  Reset mid-operation: start and out_valid drop immediately; the in-flight op is discarded; IDLE on release.
//  Inputs in_a, in_b and in_op are sampled only on the accept edge; later changes have no effect.
// TESTING
//  1.0+1.0: in_a=in_b=32'h3F800000, op=0 ->
//     parin_exp_A/B=8'h7F, parin_mant_A/B=24'h800000, one-cycle start.
//     Model replies after 5 cycles with s=0, exp=8'h80, mant=24'h800000 -> out_result=32'h40000000, out_timeout=0.
//  Denormal: in_a=32'h00000001 -> parin_exp_A=8'h00, parin_mant_A=24'h000001.
//     in_b=32'hBF800000 -> parin_s_B=1, parin_mant_B=24'h800000.
//  Backpressure: hold out_ready=0 for 10 cycles in HOLD ->
//     out_valid=1 and out_result unchanged throughout; in_ready=0; a new in_valid is not accepted.
//  Timeout: TIMEOUT_CYCLES=16, done never asserted ->
//     out_valid rises 17 cycles after ISSUE; out_result=32'h7FC00000, out_timeout=1.
//  Zero result: model returns s=1, exp=8'h05, mant=24'h000000 -> out_result=32'h80000000.
//  Reset in WAIT: drop rst for 1 cycle -> start=0, out_valid=0 asynchronously.
//     in_ready=1 after release; the late done pulse is ignored.

Source files
------------

// File: rtl/fp_add_issuer_if.sv
// Bundle of host-side valid/ready channels and adder-side start/done port for fp_add_issuer.
// master is the issuer's view; slave is the host/adder environment's view.
interface fp_add_issuer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;
  logic        parin_s_A;
  logic [7:0]  parin_exp_A;
  logic [23:0] parin_mant_A;
  logic        parin_s_B;
  logic [7:0]  parin_exp_B;
  logic [23:0] parin_mant_B;
  logic        operator;
  logic        start;
  logic        done;
  logic        s_outR;
  logic [7:0]  exp_outR;
  logic [23:0] mant_outR;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_timeout;

  modport master (
    input  in_valid, in_a, in_b, in_op, done, s_outR, exp_outR, mant_outR, out_ready,
    output in_ready, parin_s_A, parin_exp_A, parin_mant_A, parin_s_B, parin_exp_B,
           parin_mant_B, operator, start, out_valid, out_result, out_timeout
  );

  modport slave (
    output in_valid, in_a, in_b, in_op, done, s_outR, exp_outR, mant_outR, out_ready,
    input  in_ready, parin_s_A, parin_exp_A, parin_mant_A, parin_s_B, parin_exp_B,
           parin_mant_B, operator, start, out_valid, out_result, out_timeout
  );
endinterface

// File: rtl/fp_add_issuer.sv
// Host-side initiator for the FP adder: unpacks IEEE-754 singles, runs start/done with a
// watchdog, and returns the packed result (or a quiet NaN on timeout) over valid/ready.
module fp_add_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input logic               clk,
  input logic               rst,
  fp_add_issuer_if.master   bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      QNaN    = 32'h7FC00000;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_start;
  logic             r_out_valid;
  logic [31:0]      r_out_result;
  logic             r_out_timeout;
  logic             r_s_a;
  logic [7:0]       r_exp_a;
  logic [23:0]      r_mant_a;
  logic             r_s_b;
  logic [7:0]       r_exp_b;
  logic [23:0]      r_mant_b;
  logic             r_op;

  logic [23:0] w_mant_a;
  logic [23:0] w_mant_b;
  logic [31:0] w_packed;
  logic        w_unused_hidden;

  // Hidden bit is implied only for normal numbers; zero and denormals carry 0.
  assign w_mant_a = {(bus.in_a[30:23] != 8'h00), bus.in_a[22:0]};
  assign w_mant_b = {(bus.in_b[30:23] != 8'h00), bus.in_b[22:0]};

  assign w_packed = (bus.mant_outR == 24'h000000) ? {bus.s_outR, 31'b0}
                                                  : {bus.s_outR, bus.exp_outR,
                                                     bus.mant_outR[22:0]};
  assign w_unused_hidden = bus.mant_outR[23];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_in_ready    <= 1'b1;
      r_start       <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_timeout <= 1'b0;
      r_s_a         <= 1'b0;
      r_exp_a       <= '0;
      r_mant_a      <= '0;
      r_s_b         <= 1'b0;
      r_exp_b       <= '0;
      r_mant_b      <= '0;
      r_op          <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_s_a      <= bus.in_a[31];
            r_exp_a    <= bus.in_a[30:23];
            r_mant_a   <= w_mant_a;
            r_s_b      <= bus.in_b[31];
            r_exp_b    <= bus.in_b[30:23];
            r_mant_b   <= w_mant_b;
            r_op       <= bus.in_op;
            r_in_ready <= 1'b0;
            r_start    <= 1'b1;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          // done has priority over the terminal count
          if (bus.done) begin
            r_out_result  <= w_packed;
            r_out_timeout <= 1'b0;
            r_out_valid   <= 1'b1;
            r_state       <= StHold;
          end else if (r_cnt == TermCnt) begin
            r_out_result  <= QNaN;
            r_out_timeout <= 1'b1;
            r_out_valid   <= 1'b1;
            r_state       <= StHold;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.start        = r_start;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_result   = r_out_result;
  assign bus.out_timeout  = r_out_timeout;
  assign bus.parin_s_A    = r_s_a;
  assign bus.parin_exp_A  = r_exp_a;
  assign bus.parin_mant_A = r_mant_a;
  assign bus.parin_s_B    = r_s_b;
  assign bus.parin_exp_B  = r_exp_b;
  assign bus.parin_mant_B = r_mant_b;
  assign bus.operator     = r_op;

endmodule

// File: tb/tb_fp_add_issuer.sv
// Directed self-checking bench for fp_add_issuer; the bench itself plays host and adder.
module tb_fp_add_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_wait;

  fp_add_issuer_if bus ();

  fp_add_issuer #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer an operand pair; returns at the negedge where ISSUE is visible.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    @(negedge clk);
    check("start_hi", 32'(bus.start), 32'd1);
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    bus.in_a     = 32'hDEADBEEF;
    bus.in_b     = 32'h12345678;
    bus.in_op    = ~op;
  endtask

  // Adder model: answers `delay` cycles after ISSUE; returns in HOLD.
  task automatic respond(input int delay, input logic s, input logic [7:0] e,
                         input logic [23:0] m);
    @(negedge clk);
    check("start_pulse", 32'(bus.start), 32'd0);
    repeat (delay - 1) @(negedge clk);
    bus.done      = 1'b1;
    bus.s_outR    = s;
    bus.exp_outR  = e;
    bus.mant_outR = m;
    @(negedge clk);
    bus.done = 1'b0;
    check("out_valid_hi", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hs_out_valid", 32'(bus.out_valid), 32'd0);
    check("hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 1'b0;
    bus.done      = 1'b0;
    bus.s_outR    = 1'b0;
    bus.exp_outR  = '0;
    bus.mant_outR = '0;
    bus.out_ready = 1'b0;

    #1 rst = 1'b0;
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.out_result, 32'h0);
    check("rst_timeout", 32'(bus.out_timeout), 32'd0);
    check("rst_mant_a", 32'(bus.parin_mant_A), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // 1.0 + 1.0
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    check("one_exp_a", 32'(bus.parin_exp_A), 32'h7F);
    check("one_mant_a", 32'(bus.parin_mant_A), 32'h800000);
    check("one_exp_b", 32'(bus.parin_exp_B), 32'h7F);
    check("one_mant_b", 32'(bus.parin_mant_B), 32'h800000);
    check("one_op", 32'(bus.operator), 32'd0);
    respond(5, 1'b0, 8'h80, 24'h800000);
    check("one_result", bus.out_result, 32'h40000000);
    check("one_timeout", 32'(bus.out_timeout), 32'd0);
    check("one_sampled_a", 32'(bus.parin_mant_A), 32'h800000);
    handshake();

    // Denormal A, negative B, subtract
    issue(32'h00000001, 32'hBF800000, 1'b1);
    check("den_exp_a", 32'(bus.parin_exp_A), 32'h00);
    check("den_mant_a", 32'(bus.parin_mant_A), 32'h000001);
    check("den_s_a", 32'(bus.parin_s_A), 32'd0);
    check("den_s_b", 32'(bus.parin_s_B), 32'd1);
    check("den_mant_b", 32'(bus.parin_mant_B), 32'h800000);
    check("den_op", 32'(bus.operator), 32'd1);
    respond(3, 1'b0, 8'h7F, 24'h800000);
    check("den_result", bus.out_result, 32'h3F800000);
    handshake();
    check("den_hold_op", 32'(bus.operator), 32'd1);

    // Backpressure: result held, new request ignored
    issue(32'h40000000, 32'h3F800000, 1'b0);
    respond(2, 1'b0, 8'h80, 24'hC00000);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h40400000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result", bus.out_result, 32'h40400000);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    check("bp_no_accept", 32'(bus.parin_exp_A), 32'h80);
    bus.in_valid = 1'b0;
    handshake();

    // Watchdog: adder never answers
    issue(32'h3F800000, 32'h40000000, 1'b0);
    n_wait = 0;
    while (!bus.out_valid && n_wait < 40) begin
      @(negedge clk);
      n_wait++;
    end
    check("to_latency", 32'(n_wait), 32'd17);
    check("to_result", bus.out_result, 32'h7FC00000);
    check("to_flag", 32'(bus.out_timeout), 32'd1);
    handshake();

    // Zero result collapses exponent
    issue(32'h3F800000, 32'h3F800000, 1'b1);
    respond(4, 1'b1, 8'h05, 24'h000000);
    check("zero_result", bus.out_result, 32'h80000000);
    check("zero_timeout", 32'(bus.out_timeout), 32'd0);
    handshake();

    // Reset during ISSUE drops start asynchronously
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("rsti_start", 32'(bus.start), 32'd0);
    check("rsti_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Reset in WAIT, then a late done is ignored
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstw_start", 32'(bus.start), 32'd0);
    check("rstw_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check("rstw_in_ready", 32'(bus.in_ready), 32'd1);
    bus.done      = 1'b1;
    bus.s_outR    = 1'b0;
    bus.exp_outR  = 8'h80;
    bus.mant_outR = 24'h800000;
    @(negedge clk);
    bus.done = 1'b0;
    @(negedge clk);
    check("late_done_valid", 32'(bus.out_valid), 32'd0);
    check("late_done_ready", 32'(bus.in_ready), 32'd1);

    // Reset in HOLD drops out_valid asynchronously
    issue(32'h3F800000, 32'h3F800000, 1'b0);
    respond(2, 1'b0, 8'h80, 24'h800000);
    #2 rst = 1'b0;
    #1;
    check("rsth_out_valid", 32'(bus.out_valid), 32'd0);
    check("rsth_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
